// File: rtl/cpu_pkg.sv
// Shared types and encoding constants for the execute sequencer and its ALU.
package cpu_pkg;

    // Default widths; DATA_W must be 2*REG_ADDR_W so the immediate fits the rs1/rs2 field.
    localparam int REG_ADDR_W_DEF = 2;
    localparam int DATA_W_DEF     = 2 * REG_ADDR_W_DEF;
    localparam int CNT_W_DEF      = 8;

    // Instruction layout for the default widths: [7:6] op, [5:4] rd, [3:2] rs1, [1:0] rs2.
    localparam int INSTR_W_DEF = 2 + 3 * REG_ADDR_W_DEF;
    localparam int OP_LSB      = 3 * REG_ADDR_W_DEF;
    localparam int RD_LSB      = 2 * REG_ADDR_W_DEF;
    localparam int RS1_LSB     = REG_ADDR_W_DEF;
    localparam int RS2_LSB     = 0;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_AND = 2'b10,
        OP_LI  = 2'b11
    } op_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        READ = 2'b01,
        EXEC = 2'b10,
        WB   = 2'b11
    } seq_state_t;

endpackage

// File: rtl/exec_sequencer_alu4.sv
// Purely combinational ALU: ADD/SUB/AND on two operands, LI passes the immediate.
module alu4
    import cpu_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  op_t               op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [DATA_W-1:0] imm,
    input  logic              carry_in,
    output logic [DATA_W-1:0] result,
    output logic              carry_out,
    output logic              zero
);

    logic [DATA_W:0] sum;
    logic [DATA_W:0] diff;

    // One extra bit carries the ADD carry-out; for SUB it is the borrow (a < b unsigned).
    assign sum  = {1'b0, a} + {1'b0, b};
    assign diff = {1'b0, a} - {1'b0, b};

    // Select result and carry by opcode; AND and LI hold the previous carry.
    always_comb begin
        result    = '0;
        carry_out = carry_in;
        case (op)
            OP_ADD: begin
                result    = sum[DATA_W-1:0];
                carry_out = sum[DATA_W];
            end
            OP_SUB: begin
                result    = diff[DATA_W-1:0];
                carry_out = diff[DATA_W];
            end
            OP_AND: result = a & b;
            OP_LI:  result = imm;
            default: result = '0;
        endcase
    end

    assign zero = (result == '0);

endmodule

// File: rtl/exec_sequencer.sv
// Four-state execute controller in front of a small register file:
// IDLE (accept) -> READ (capture operands) -> EXEC (ALU) -> WB (write back).
//
// Handshake: an instruction transfers on a rising edge where instr_valid and
// instr_ready are both high; instr_ready is high only in IDLE while rst_n is
// high, and instr/instr_valid are ignored in every other cycle.
module exec_sequencer
    import cpu_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DEF,
    parameter int REG_ADDR_W = REG_ADDR_W_DEF,
    parameter int CNT_W      = CNT_W_DEF
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      instr_valid,
    output logic                      instr_ready,
    input  logic [2+3*REG_ADDR_W-1:0] instr,
    output logic [REG_ADDR_W-1:0]     rs1,
    output logic [REG_ADDR_W-1:0]     rs2,
    input  logic [DATA_W-1:0]         ru1,
    input  logic [DATA_W-1:0]         ru2,
    output logic [REG_ADDR_W-1:0]     rd,
    output logic                      RuWr,
    output logic [DATA_W-1:0]         RuWrData,
    output logic                      busy,
    output logic                      retire,
    output logic                      zero_flag,
    output logic                      carry_flag,
    output logic [CNT_W-1:0]          instr_count,
    output seq_state_t                dbg_state
);

    localparam int INSTR_W = 2 + 3 * REG_ADDR_W;

    seq_state_t           state_q;
    logic [INSTR_W-1:0]   ir_q;
    logic [DATA_W-1:0]    opa_q;
    logic [DATA_W-1:0]    opb_q;
    logic [DATA_W-1:0]    res_q;
    logic                 zero_q;
    logic                 carry_q;
    logic [CNT_W-1:0]     cnt_q;

    logic [DATA_W-1:0]    res_d;
    logic                 zero_d;
    logic                 carry_d;
    logic [CNT_W-1:0]     cnt_d;
    op_t                  op;
    logic [DATA_W-1:0]    imm;

    // Field decode always comes from the latched instruction, never from the input bus.
    assign op  = op_t'(ir_q[INSTR_W-1 -: 2]);
    assign rd  = ir_q[3*REG_ADDR_W-1 -: REG_ADDR_W];
    assign rs1 = ir_q[2*REG_ADDR_W-1 -: REG_ADDR_W];
    assign rs2 = ir_q[REG_ADDR_W-1:0];
    // The immediate overlays the rs1/rs2 fields.
    assign imm = ir_q[DATA_W-1:0];

    alu4 #(.DATA_W(DATA_W)) u_alu (
        .op        (op),
        .a         (opa_q),
        .b         (opb_q),
        .imm       (imm),
        .carry_in  (carry_q),
        .result    (res_d),
        .carry_out (carry_d),
        .zero      (zero_d)
    );

    assign cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};

    // Sequencer: one instruction walks IDLE->READ->EXEC->WB; reset drops it without a write.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ir_q    <= '0;
            opa_q   <= '0;
            opb_q   <= '0;
            res_q   <= '0;
            zero_q  <= 1'b0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (instr_valid) begin
                        ir_q    <= instr;
                        state_q <= READ;
                    end
                end
                READ: begin
                    opa_q   <= ru1;
                    opb_q   <= ru2;
                    state_q <= EXEC;
                end
                EXEC: begin
                    res_q   <= res_d;
                    zero_q  <= zero_d;
                    carry_q <= carry_d;
                    state_q <= WB;
                end
                WB: begin
                    cnt_q   <= cnt_d;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Strobes are gated by rst_n so a reset landing in WB never writes.
    assign instr_ready = (state_q == IDLE) && rst_n;
    assign RuWr        = (state_q == WB) && rst_n;
    assign retire      = (state_q == WB) && rst_n;
    assign busy        = (state_q != IDLE);
    assign RuWrData    = res_q;
    assign zero_flag   = zero_q;
    assign carry_flag  = carry_q;
    assign instr_count = cnt_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_exec_sequencer.sv
// Directed bench for exec_sequencer with a behavioural 4x4 register file.
module tb_exec_sequencer;
    import cpu_pkg::*;

    logic       clk;
    logic       rst_n;
    logic       instr_valid;
    logic       instr_ready;
    logic [7:0] instr;
    logic [1:0] rs1, rs2, rd;
    logic [3:0] ru1, ru2;
    logic       RuWr;
    logic [3:0] RuWrData;
    logic       busy, retire, zero_flag, carry_flag;
    logic [7:0] instr_count;
    seq_state_t dbg_state;

    logic [3:0] rf [4];

    int n_checks = 0;
    int n_errors = 0;

    exec_sequencer dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr       (instr),
        .rs1         (rs1),
        .rs2         (rs2),
        .ru1         (ru1),
        .ru2         (ru2),
        .rd          (rd),
        .RuWr        (RuWr),
        .RuWrData    (RuWrData),
        .busy        (busy),
        .retire      (retire),
        .zero_flag   (zero_flag),
        .carry_flag  (carry_flag),
        .instr_count (instr_count),
        .dbg_state   (dbg_state)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register file model: combinational read, write on rising edge.
    assign ru1 = rf[rs1];
    assign ru2 = rf[rs2];
    always @(posedge clk) if (RuWr) rf[rd] <= RuWrData;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one instruction in IDLE and follow it through all four states.
    task automatic issue(input logic [7:0] ins, input logic [3:0] exp_data,
                         input logic exp_zero, input logic exp_carry,
                         input logic [7:0] exp_cnt);
        check("ready_idle", instr_ready, 1'b1);
        instr_valid = 1'b1;
        instr       = ins;
        step();                                   // E0: accepted, now READ
        instr_valid = 1'b0;
        instr       = 8'hFF;                      // bus noise must be ignored
        check("ready_read", instr_ready, 1'b0);
        check("busy_read", busy, 1'b1);
        check("rs1", rs1, ins[3:2]);
        check("rs2", rs2, ins[1:0]);
        check("wr_read", RuWr, 1'b0);
        step();                                   // E1: EXEC
        check("wr_exec", RuWr, 1'b0);
        step();                                   // E2: WB
        check("wr_wb", RuWr, 1'b1);
        check("retire_wb", retire, 1'b1);
        check("rd", rd, ins[5:4]);
        check("wdata", RuWrData, exp_data);
        check("zero", zero_flag, exp_zero);
        check("carry", carry_flag, exp_carry);
        step();                                   // E3: back to IDLE
        check("wr_after", RuWr, 1'b0);
        check("count", instr_count, exp_cnt);
        check("rf_write", rf[ins[5:4]], exp_data);
    endtask

    logic [7:0] bb_list [3];
    logic [7:0] exp_cnt;

    initial begin
        rst_n       = 1'b0;
        instr_valid = 1'b0;
        instr       = 8'h00;
        for (int i = 0; i < 4; i++) rf[i] = 4'h0;
        step();
        step();
        // Reset state
        check("rst_ready", instr_ready, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_wr", RuWr, 1'b0);
        check("rst_cnt", instr_count, 8'd0);
        check("rst_zero", zero_flag, 1'b0);
        check("rst_carry", carry_flag, 1'b0);
        check("rst_wdata", RuWrData, 4'h0);
        check("rst_rd", rd, 2'd0);
        check("rst_state", dbg_state, IDLE);
        rst_n = 1'b1;
        #1;

        // Directed instruction stream with hand-computed results
        issue(8'hD5, 4'h5, 1'b0, 1'b0, 8'd1);  // LI  r1,5
        issue(8'hEB, 4'hB, 1'b0, 1'b0, 8'd2);  // LI  r2,B
        issue(8'h36, 4'h0, 1'b1, 1'b1, 8'd3);  // ADD r3,r1,r2: 5+B=0x10
        issue(8'h46, 4'hA, 1'b0, 1'b1, 8'd4);  // SUB r0,r1,r2: 5-B borrow
        issue(8'h86, 4'h1, 1'b0, 1'b1, 8'd5);  // AND r0,r1,r2: carry held
        issue(8'h79, 4'h6, 1'b0, 1'b0, 8'd6);  // SUB r3,r2,r1: B-5
        issue(8'h0F, 4'hC, 1'b0, 1'b0, 8'd7);  // ADD r0,r3,r3: 6+6
        issue(8'hC0, 4'h0, 1'b1, 1'b0, 8'd8);  // LI  r0,0
        issue(8'h92, 4'h0, 1'b1, 1'b0, 8'd9);  // AND r1,r0,r2

        // instr_valid held high: one acceptance per 4 cycles
        bb_list[0] = 8'hD1;                     // LI  r1,1
        bb_list[1] = 8'hE2;                     // LI  r2,2
        bb_list[2] = 8'h36;                     // ADD r3,r1,r2
        instr_valid = 1'b1;
        for (int c = 0; c < 12; c++) begin
            check("bb_ready", instr_ready, (c % 4) == 0);
            if ((c % 4) == 0) instr = bb_list[c / 4];
            step();
        end
        instr_valid = 1'b0;
        check("bb_count", instr_count, 8'd12);
        check("bb_r3", rf[3], 4'h3);
        check("bb_carry", carry_flag, 1'b0);

        // Set both flags before the mid-WB reset
        issue(8'h46, 4'hF, 1'b0, 1'b1, 8'd13); // SUB r0,r1,r2: 1-2
        issue(8'hC0, 4'h0, 1'b1, 1'b1, 8'd14); // LI  r0,0

        // Reset asserted during WB drops the write
        instr_valid = 1'b1;
        instr       = 8'hC7;                    // LI r0,7
        step();
        instr_valid = 1'b0;
        step();
        step();
        check("wb_state", dbg_state, WB);
        rst_n = 1'b0;
        #1;
        check("rstwb_wr", RuWr, 1'b0);
        check("rstwb_retire", retire, 1'b0);
        check("rstwb_ready", instr_ready, 1'b0);
        step();
        check("rstwb_rf0", rf[0], 4'h0);
        check("rstwb_busy", busy, 1'b0);
        check("rstwb_zero", zero_flag, 1'b0);
        check("rstwb_carry", carry_flag, 1'b0);
        check("rstwb_cnt", instr_count, 8'd0);
        check("rstwb_wdata", RuWrData, 4'h0);
        rst_n = 1'b1;
        #1;
        check("rstwb_ready_up", instr_ready, 1'b1);
        issue(8'hE9, 4'h9, 1'b0, 1'b0, 8'd1);  // LI r2,9 after reset

        // Counter wrap: 255 more LI instructions take it from 1 through 255 to 0
        exp_cnt = 8'd1;
        for (int k = 0; k < 255; k++) begin
            logic [3:0] v;
            v = 4'($urandom_range(0, 15));
            exp_cnt = exp_cnt + 8'd1;
            issue({4'b1101, v}, v, v == 4'h0, 1'b0, exp_cnt);
        end
        check("wrap_cnt", instr_count, 8'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/exec_sequencer.md
Name: exec_sequencer

Overview:
Multi-cycle execute controller that sits directly upstream of the 4-entry x 4-bit register file. It accepts one 8-bit instruction at a time through a valid/ready handshake. It drives the register file's read selects (rs1/rs2), captures its read data (ru1/ru2) and computes a 4-bit ALU result. It then writes the result back through rd/RuWr/RuWrData. It also keeps zero/carry flags and a retired-instruction counter.

Parameters:
- DATA_W, 4, register/ALU data width; must equal 2*REG_ADDR_W because the immediate occupies the rs1/rs2 field.
- REG_ADDR_W, 2, register select width.
- CNT_W, 8, width of the retired-instruction counter.

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- instr_valid  in  1  upstream presents an instruction.
- instr_ready  out  1  block can accept an instruction this cycle.
- instr  in  2+3*REG_ADDR_W (8)  encoding [7:6] op, [5:4] rd, [3:2] rs1, [1:0] rs2; imm4 = [3:0].
- rs1  out  REG_ADDR_W  register file read select A.
- rs2  out  REG_ADDR_W  register file read select B.
- ru1  in  DATA_W  register file read data A (combinational from rs1).
- ru2  in  DATA_W  register file read data B.
- rd  out  REG_ADDR_W  register file write select.
- RuWr  out  1  register file write enable.
- RuWrData  out  DATA_W  register file write data.
- busy  out  1  high whenever state != IDLE.
- retire  out  1  one-cycle pulse in WB.
- zero_flag  out  1  last result == 0.
- carry_flag  out  1  ADD carry-out / SUB borrow.
- instr_count  out  CNT_W  number of retired instructions.

Behaviour:
- Opcodes:
  - 00 ADD: rd = rs1 + rs2.
  - 01 SUB: rd = rs1 - rs2.
  - 10 AND: rd = rs1 & rs2.
  - 11 LI: rd = imm4.
- FSM states: IDLE, READ, EXEC, WB. Every instruction, including LI, takes all four states.
- IDLE:
  - instr_ready = 1 (gated by rst_n).
  - On instr_valid && instr_ready at edge E0: latch instr into ir, go to READ.
  - instr is ignored when not ready. instr_valid may drop or change freely without effect.
- READ:
  - rs1/rs2 are driven from ir.
  - At E1: capture ru1 -> opa, ru2 -> opb; go to EXEC.
- EXEC:
  - ALU operates on opa/opb/ir.
  - At E2: result -> res, flags updated; go to WB.
- WB:
  - RuWr = 1, rd = ir[5:4], RuWrData = res, retire = 1.
  - At E3: register file writes, instr_count increments, go to IDLE.
- Latency and throughput:
  - Acceptance at E0 -> RuWr high during the cycle between E2 and E3.
  - Throughput is one instruction per 4 cycles.
  - instr_ready is low in READ/EXEC/WB; no back-to-back acceptance.
- Output encoding:
  - rs1/rs2/rd always decode from ir; RuWrData always equals res. Only RuWr qualifies a write.
  - RuWr = (state==WB) && rst_n.
  - retire = (state==WB) && rst_n.
  - instr_ready = (state==IDLE) && rst_n.
- Arithmetic: DATA_W+1-bit internal sums; result truncated to DATA_W. Wrap-around is natural.
- Flags:
  - ADD: carry = bit DATA_W of the sum.
  - SUB: carry = borrow, i.e. 1 iff opa < opb unsigned.
  - AND and LI leave carry unchanged.
  - zero updates on every op.
- instr_count wraps from 2^CNT_W-1 to 0.
- Reset (rst_n low at any edge, including mid-instruction):
  - state = IDLE.
  - ir, opa, opb, res = 0, so rs1 = rs2 = rd = 0 and RuWrData = 0.
  - zero_flag = 0, carry_flag = 0, instr_count = 0, busy = 0.
  - The in-flight instruction is dropped with no write. RuWr is low in any cycle where rst_n is low, including WB.
- Register file contents are not reset. Software must LI before reading a register.

Decomposition:
- Package cpu_pkg:
  - op_t enum (OP_ADD, OP_SUB, OP_AND, OP_LI).
  - seq_state_t enum (IDLE, READ, EXEC, WB).
  - Field-position constants for the instr encoding.
  - DATA_W/REG_ADDR_W defaults.
- One natural sub-module: alu4, purely combinational. Inputs op, a, b, imm, carry_in. Outputs result, carry_out, zero.

Test Plan:
- Reset then LI r1,5 (instr=0xD5) -> instr_ready drops after E0; 3 cycles later a 1-cycle RuWr=1 with rd=1, RuWrData=5; zero_flag=0; instr_count=1.
- LI r2,0xB (0xEB); ADD r3,r1,r2 (0x36) -> rs1=1, rs2=2 in READ; write rd=3 data=0x0; carry_flag=1, zero_flag=1.
- SUB r0,r1,r2 (0x46) with r1=5, r2=0xB -> write rd=0 data=0xA; carry_flag=1 (borrow), zero_flag=0.
- AND r0,r1,r2 (0x86) after previous SUB -> write data=0x1; carry_flag stays 1; zero_flag=0.
- instr_valid held high with 3 queued instructions -> exactly one acceptance per 4 cycles; instr_ready high only in IDLE; instr_count=3 after 12 cycles.
- rst_n low for one edge while in WB -> RuWr=0 that cycle and no write observed; next cycle state IDLE, instr_ready=1, flags=0, instr_count=0.
